// File: rtl/shftreg_pkg.sv
// ---------------------------------------------------------------------------
// shftreg_pkg
// Shared types and helpers for the LSB-first serial receiver (shftreg_rx).
//   state_t       : receiver FSM states (IDLE, RECV)
//   DEFAULT_WIDTH : default data word width
//   frame_len()   : serial frame length in strobes for a given data width
// Optional feature macro: PARITY_CHECK_EN (adds one even-parity bit per frame).
// ---------------------------------------------------------------------------
package shftreg_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Number of strobes per frame: data bits, plus the trailing parity bit
    // when parity checking is built in.
    function automatic int frame_len(input int width);
`ifdef PARITY_CHECK_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/shftreg_bitcnt.sv
// ---------------------------------------------------------------------------
// shftreg_bitcnt
// Modulo-N bit counter with enable and terminal-count flag.
// Ports:
//   clk  in  clock, rising edge
//   rst  in  asynchronous active-high reset (count -> 0)
//   en   in  count enable; wraps to 0 after N-1
//   tc   out count currently equals N-1
// ---------------------------------------------------------------------------
module shftreg_bitcnt #(
    parameter int N  = 4,
    parameter int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tc
);

    logic [CW-1:0] cnt;

    assign tc = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/shftreg_rx.sv
// ---------------------------------------------------------------------------
// shftreg_rx
// Serial-in/parallel-out receiver. One bit is sampled on each rising CLK
// with SHFT=1, LSB first; every completed WIDTH-bit word is loaded into an
// output register with a Valid/RD handshake and an overrun flag.
// Ports:
//   CLK     in   system clock, rising edge
//   Clear   in   asynchronous active-high reset
//   SHFT    in   bit strobe
//   InS     in   serial data, LSB first
//   RD      in   consumer acknowledge (effective only while Valid=1)
//   Q       out  last completed word
//   Valid   out  Q holds an unread word
//   Ovr     out  a word completed while the previous one was unread
//   Busy    out  a frame is partly received
//   ParErr  out  parity error on current Q (0 unless PARITY_CHECK_EN)
// Optional feature macro: PARITY_CHECK_EN -- each frame carries a trailing
// even-parity bit over the data bits, checked at completion.
// ---------------------------------------------------------------------------
module shftreg_rx
    import shftreg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             SHFT,
    input  logic             InS,
    input  logic             RD,
    output logic [WIDTH-1:0] Q,
    output logic             Valid,
    output logic             Ovr,
    output logic             Busy,
    output logic             ParErr
);

    localparam int FRAME_LEN = frame_len(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic             last_bit;
    logic             done;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_nxt;

    // ---- bit counter: terminal count marks the final strobe of a frame ----
    shftreg_bitcnt #(
        .N (FRAME_LEN)
    ) u_bitcnt (
        .clk (CLK),
        .rst (Clear),
        .en  (SHFT),
        .tc  (last_bit)
    );

    assign done   = SHFT & last_bit;
    assign sr_nxt = {InS, sr[WIDTH-1:1]};

    // ---- FSM: state register ----
    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (SHFT) state_nxt = last_bit ? IDLE : RECV;
            RECV: if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        Busy = 1'b0;
        if (state == RECV) begin
            Busy = 1'b1;
        end
    end

    // ---- shift path and output buffer ----
`ifdef PARITY_CHECK_EN
    logic par_err;

    // The parity strobe is checked, not shifted, so sr keeps the data word.
    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            sr <= '0;
        end else if (SHFT && !last_bit) begin
            sr <= sr_nxt;
        end
    end

    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            Q       <= '0;
            par_err <= 1'b0;
        end else if (done) begin
            Q       <= sr;
            // Even parity: data bits XOR parity bit must be 0.
            par_err <= (^sr) ^ InS;
        end
    end

    assign ParErr = par_err;
`else
    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            sr <= '0;
        end else if (SHFT) begin
            sr <= sr_nxt;
        end
    end

    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            Q <= '0;
        end else if (done) begin
            Q <= sr_nxt;
        end
    end

    assign ParErr = 1'b0;
`endif

    // ---- handshake: completion wins over RD; RD in the same edge only
    //      suppresses the overrun and clears the old flag ----
    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            Valid <= 1'b0;
            Ovr   <= 1'b0;
        end else if (done) begin
            Valid <= 1'b1;
            Ovr   <= Valid & ~RD;
        end else if (RD && Valid) begin
            Valid <= 1'b0;
            Ovr   <= 1'b0;
        end
    end

endmodule

// File: doc/shftreg_rx.md
Name: shftreg_rx

Overview:
- Serial-in/parallel-out receiver: the far end of the right-shift parallel-load transmitter.
- Samples one serial bit per enabled clock, LSB first, and assembles WIDTH-bit words.
- Each completed word goes to a double-buffered output register with a valid/read handshake and an overrun flag.
- Sits directly on the transmitter's serial line, or on any LSB-first shift link in the design.

Parameters:
- WIDTH, 4, data word width in bits (minimum 2).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- Clear  in  1  asynchronous active-high reset.
- SHFT  in  1  bit strobe; InS is sampled on each rising CLK with SHFT=1.
- InS  in  1  serial data, LSB first.
- RD  in  1  consumer acknowledge; takes effect only while Valid=1.
- Q  out  WIDTH  last completed word; stable while Valid=1 unless an overrun occurs.
- Valid  out  1  Q holds an unread word.
- Ovr  out  1  a word completed while the previous one was unread.
- Busy  out  1  a frame is partly received (state RECV).
- ParErr  out  1  parity error on the current Q (PARITY_CHECK_EN only); tied 0 otherwise.

Behaviour:
- Reset: Clear=1 forces the following at once, independent of CLK:
  - Q=0, Valid=0, Ovr=0, Busy=0, ParErr=0;
  - shift register sr=0, bit counter cnt=0, state=IDLE.
- Clear mid-frame discards the partial frame; the next SHFT starts a new frame at bit 0.
- States and transitions:
  - IDLE: no partial frame. SHFT=1 moves to RECV, or completes the frame directly if FRAME_LEN=1 (impossible for WIDTH>=2).
  - RECV: partial frame held. When SHFT=1 and cnt=FRAME_LEN-1, the frame completes and the state returns to IDLE.
  - FRAME_LEN = WIDTH, or WIDTH+1 with the parity option.
- Shift: on each SHFT=1 edge, sr <= {InS, sr[WIDTH-1:1]} and cnt <= cnt+1. The first bit received ends in Q[0].
- SHFT=0 holds sr, cnt and state indefinitely. There is no timeout.
- Completion edge:
  - Q <= {InS, sr[WIDTH-1:1]}, Valid <= 1, cnt <= 0.
  - Valid is visible on the cycle after the edge that sampled the last bit (latency 1 clock from the last strobe).
- Handshake: RD=1 with Valid=1 clears Valid and Ovr on the next edge. RD while Valid=0 is ignored.
- Overrun: a completion with Valid=1 and RD=0 overwrites Q (newest word wins), keeps Valid=1 and sets Ovr=1. Ovr stays set until RD or Clear.
- Completion and RD on the same edge: the new word is loaded, Valid stays 1, no overrun is flagged, and the old Ovr is cleared.
- Back-to-back frames: the first bit of the next frame may be strobed on the cycle right after completion, with no gap.
- Busy=1 exactly while 0 < cnt < FRAME_LEN.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- When defined:
  - Each frame carries one extra bit after the data bits: an even-parity bit over the WIDTH data bits.
  - The parity bit is not shifted into sr; it is checked at completion.
  - ParErr is loaded together with Q and follows the same clear rules as Q (reset only; it updates on each completion).
  - A parity error still sets Valid.
- When undefined:
  - FRAME_LEN=WIDTH and ParErr is a constant 0.
  - No parity logic is present.

Decomposition:
- Package shftreg_pkg:
  - state enum {IDLE, RECV};
  - DEFAULT_WIDTH=4;
  - function frame_len(width) returning the frame length, with the PARITY_CHECK_EN variant.
- Sub-module shftreg_bitcnt: a modulo-FRAME_LEN counter with enable and a terminal-count output. This is the only natural split.
- Shift path, output buffer and handshake stay in the top module.

Test Plan (WIDTH=4 unless noted):
- Reset: Clear=1 at t=5 ns mid-simulation -> all outputs 0 immediately, with no clock edge required.
- Basic frame: SHFT=1 for 4 cycles with InS=1,0,1,0 -> Q=4'b0101 and Valid=1 one cycle after the 4th strobe; Busy=1 during bits 2-4; RD for one cycle -> Valid=0.
- Stalled frame: bits 1,1 then SHFT=0 for 10 cycles, then bits 0,0 -> Q=4'b0011; Busy held high through the stall.
- Overrun: word 0101 left unread, then a second frame 1,1,1,1 -> Q=4'b1111, Valid=1, Ovr=1; RD -> Valid=0, Ovr=0.
- Collision and reset: RD asserted on the completion edge of frame 2 -> Valid=1, Ovr=0, Q=new word. Clear after 2 bits, then a full frame 0,1,1,0 -> Q=4'b0110.
- Parity (PARITY_CHECK_EN): data 1,0,1,0 + parity 0 -> ParErr=0; data 1,0,0,0 + parity 0 -> ParErr=1, Valid=1, Q=4'b0001.
